// File: rtl/regfile_scan_reader_pkg.sv
// regfile_scan_reader_pkg: shared processor constants and scan-reader state encoding
package regfile_scan_reader_pkg;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_WIDTH = 32;
    typedef enum logic [2:0] {IDLE, ADDR, CAPTURE, SEND, DONE} state_t;
endpackage

// File: rtl/regfile_scan_reader.sv
// regfile_scan_reader: walks the register bank once per start and streams each word out
module regfile_scan_reader
    import regfile_scan_reader_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int WIDTH = DEF_WIDTH,
    localparam int IDX_W = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    output logic             busy,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             done
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);
    state_t state;
    logic [IDX_W-1:0] index;
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            index <= '0;
            busy <= 1'b0;
            rd_addr <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_index <= '0;
            out_last <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= ADDR;
                    index <= '0;
                    rd_addr <= '0;
                    busy <= 1'b1;
                end
                ADDR: state <= CAPTURE;
                CAPTURE: begin
                    out_data <= rd_data;
                    out_index <= index;
                    out_last <= index == LAST;
                    out_valid <= 1'b1;
                    state <= SEND;
                end
                SEND: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last <= 1'b0;
                    // the final-entry compare is what keeps index from wrapping
                    if (index == LAST) begin
                        state <= DONE;
                        done <= 1'b1;
                    end else begin
                        index <= index + 1'b1;
                        rd_addr <= index + 1'b1;
                        state <= ADDR;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_scan_reader.sv
// tb_regfile_scan_reader: directed checks of scan order, timing, backpressure, reset and writes
module tb_regfile_scan_reader;
    localparam int N = 32;
    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } word_t;
    typedef struct {
        logic        busy;
        logic        valid;
        logic        last;
        logic        done;
        logic        idx;
        logic [31:0] data;
    } step_t;

    logic clk = 1'b0, clr = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic busy, out_valid, out_last, done;
    logic [4:0] rd_addr, out_index;
    logic [31:0] rd_data, out_data;
    logic start2 = 1'b0, out_ready2 = 1'b1;
    logic busy2, out_valid2, out_last2, done2, rd_addr2, out_index2;
    logic [31:0] rd_data2, out_data2;
    logic [31:0] bank [N];
    logic [31:0] bank2 [2];
    word_t exp_w [N];
    step_t exp_s [8];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;
    assign rd_data = bank[rd_addr];
    assign rd_data2 = bank2[rd_addr2];

    regfile_scan_reader #(.NUM_REGS(32), .WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .done(done)
    );
    regfile_scan_reader #(.NUM_REGS(2), .WIDTH(32)) dut2 (
        .clk(clk), .clr(clr), .start(start2), .busy(busy2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_index(out_index2),
        .out_last(out_last2), .done(done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_index"}, out_index, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode 0: ready held high, 1: random ready, 2: start re-pulsed at entry 5 and in DONE
    // wr 1: write bank[3] during entry 3 ADDR, wr 2: write it during entry 3 SEND
    task automatic scan(input int mode, input int wr);
        int e = 0, words = 0, dones = 0, done_e = -1, stalls = 0, first_v = -1, bad = 0;
        int seen [N];
        logic pv = 1'b0, pr = 1'b0, wr_next = 1'b0, poked = 1'b0, wdone = 1'b0, fin = 1'b0;
        logic [31:0] pd = '0;
        logic [4:0] pi = '0;
        foreach (seen[i]) seen[i] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("addr_after_start", rd_addr, 0);
        while (e < 400) begin
            if (done_e >= 0 && e == done_e + 1) begin
                chk("busy_after_done", busy, 0);
                chk("done_one_cycle", done, 0);
                fin = 1'b1;
                break;
            end
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && first_v < 0) first_v = e;
            if (pv && !pr) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, pd);
                chk("stall_index", out_index, pi);
            end
            if (out_valid && !out_ready) stalls++;
            if (out_valid && out_ready) begin
                seen[out_index]++;
                if (words < N) begin
                    chk("word_index", out_index, exp_w[words].idx);
                    chk("word_data", out_data, exp_w[words].data);
                    chk("word_last", out_last, exp_w[words].last);
                end
                words++;
            end
            if (done) begin
                dones++;
                if (done_e < 0) done_e = e;
            end
            if (mode == 2 && ((out_valid && out_index == 5 && !poked) || done)) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if ((wr == 1 && wr_next) || (wr == 2 && out_valid && out_index == 3 && !wdone)) begin
                @(negedge clk);
                bank[3] = 32'hDEADBEEF;
                wdone = 1'b1;
            end
            wr_next = out_valid && out_ready && out_index == 2;
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            pi = out_index;
            tick();
            start = 1'b0;
            e++;
        end
        foreach (seen[i]) if (seen[i] != 1) bad++;
        chk("scan_finished", fin, 1);
        chk("word_count", words, N);
        chk("dup_or_missing", bad, 0);
        chk("done_pulses", dones, 1);
        chk("done_edge", done_e, 96 + stalls);
        chk("first_valid_edge", first_v, 2);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            bank[i] = i * 32'h11111111;
            exp_w[i] = '{idx: 5'(i), data: i * 32'h11111111, last: i == N - 1};
        end
        bank2[0] = 32'hA5A50001;
        bank2[1] = 32'h5A5A0002;
        exp_s[0] = '{busy: 1, valid: 0, last: 0, done: 0, idx: 0, data: 0};
        exp_s[1] = '{busy: 1, valid: 0, last: 0, done: 0, idx: 0, data: 0};
        exp_s[2] = '{busy: 1, valid: 1, last: 0, done: 0, idx: 0, data: 32'hA5A50001};
        exp_s[3] = '{busy: 1, valid: 0, last: 0, done: 0, idx: 0, data: 0};
        exp_s[4] = '{busy: 1, valid: 0, last: 0, done: 0, idx: 0, data: 0};
        exp_s[5] = '{busy: 1, valid: 1, last: 1, done: 0, idx: 1, data: 32'h5A5A0002};
        exp_s[6] = '{busy: 1, valid: 0, last: 0, done: 1, idx: 0, data: 0};
        exp_s[7] = '{busy: 0, valid: 0, last: 0, done: 0, idx: 0, data: 0};

        tick();
        tick();
        clr = 1'b0;
        chk_all_zero("reset");

        scan(0, 0);
        scan(1, 0);
        scan(2, 0);

        exp_w[3].data = 32'hDEADBEEF;
        scan(0, 1);
        bank[3] = 32'h33333333;
        exp_w[3].data = 32'h33333333;
        scan(0, 2);
        bank[3] = 32'h33333333;

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 200 && !(out_valid && out_index == 10); k++) tick();
        out_ready = 1'b0;
        chk("reach_entry10", out_index, 10);
        tick();
        chk("entry10_held", out_valid, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b1;
        chk_all_zero("midscan_clr");
        scan(0, 0);

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int e = 0; e < 8; e++) begin
            chk("min_busy", busy2, exp_s[e].busy);
            chk("min_valid", out_valid2, exp_s[e].valid);
            chk("min_last", out_last2, exp_s[e].last);
            chk("min_done", done2, exp_s[e].done);
            if (exp_s[e].valid) begin
                chk("min_index", out_index2, exp_s[e].idx);
                chk("min_data", out_data2, exp_s[e].data);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
